// File: rtl/div_pkg.sv
`default_nettype none
// =============================================================================
// div_pkg : operation/state encodings and arithmetic helpers for seq_divider
// Rev 1.0
// =============================================================================
package div_pkg;

  localparam int DIV_MAX_XLEN = 64;
  localparam logic [DIV_MAX_XLEN-1:0] DIV_MSB_ONE = {1'b1, {(DIV_MAX_XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  // Most negative xlen-bit value, right-aligned in a DIV_MAX_XLEN word.
  function automatic logic [DIV_MAX_XLEN-1:0] ovf_dividend(input int xlen);
    return DIV_MSB_ONE >> (DIV_MAX_XLEN - xlen);
  endfunction

  function automatic logic [DIV_MAX_XLEN-1:0] abs_xlen(input logic [DIV_MAX_XLEN-1:0] x,
                                                      input int xlen);
    logic [DIV_MAX_XLEN-1:0] msb;
    logic [DIV_MAX_XLEN-1:0] mask;
    msb  = ovf_dividend(xlen);
    mask = (msb << 1) - DIV_MAX_XLEN'(1);
    if ((x & msb) != '0) begin
      return (~x + DIV_MAX_XLEN'(1)) & mask;
    end
    return x & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// =============================================================================
// seq_divider_if : request/response handshake bundle for seq_divider
// Rev 1.0
// =============================================================================
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  div_op_e         i_op;
  logic [XLEN-1:0] i_dividend;
  logic [XLEN-1:0] i_divisor;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_busy;

  modport master (
    output i_valid, i_op, i_dividend, i_divisor, i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );

  modport slave (
    input  i_valid, i_op, i_dividend, i_divisor, i_ready,
    output o_ready, o_valid, o_result, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// =============================================================================
// div_step : one restoring-division iteration (trial subtract and select)
// Rev 1.0
// =============================================================================
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_shifted,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            quo_bit
);
  logic [XLEN:0] trial;

  // rem_shifted < 2*divisor, so the (XLEN+1)-bit MSB is a reliable sign.
  always_comb begin
    trial    = rem_shifted - {1'b0, divisor};
    quo_bit  = ~trial[XLEN];
    rem_next = trial[XLEN] ? rem_shifted[XLEN-1:0] : trial[XLEN-1:0];
  end
endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// =============================================================================
// seq_divider : iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Build option: DIV_EARLY_OUT_EN (skip iterations when |dividend| < |divisor>)
// Rev 1.0
// =============================================================================
module seq_divider
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic          i_clk,
  input logic          i_rst_n,
  seq_divider_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            op_rem_q, op_rem_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic            signed_op;
  logic            div_zero;
  logic            sgn_ovf;
  logic [XLEN-1:0] abs_dvd;
  logic [XLEN-1:0] abs_dvs;
  logic [XLEN-1:0] step_rem;
  logic            step_bit;
  logic [XLEN-1:0] fix_quo;
  logic [XLEN-1:0] fix_rem;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_shifted ({rem_q, quo_q[XLEN-1]}),
    .divisor     (dvs_q),
    .rem_next    (step_rem),
    .quo_bit     (step_bit)
  );

  always_comb begin
    signed_op = ~bus.i_op[0];
    div_zero  = (bus.i_divisor == '0);
    sgn_ovf   = signed_op && (bus.i_dividend == XLEN'(ovf_dividend(XLEN))) && (&bus.i_divisor);
    abs_dvd   = signed_op ? XLEN'(abs_xlen(DIV_MAX_XLEN'(bus.i_dividend), XLEN)) : bus.i_dividend;
    abs_dvs   = signed_op ? XLEN'(abs_xlen(DIV_MAX_XLEN'(bus.i_divisor), XLEN)) : bus.i_divisor;
    fix_quo   = q_neg_q ? (~quo_q + XLEN'(1)) : quo_q;
    fix_rem   = r_neg_q ? (~rem_q + XLEN'(1)) : rem_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    op_rem_d = op_rem_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          op_rem_d = bus.i_op[1];
          q_neg_d  = signed_op & (bus.i_dividend[XLEN-1] ^ bus.i_divisor[XLEN-1]);
          r_neg_d  = signed_op & bus.i_dividend[XLEN-1];
          dvs_d    = abs_dvs;
          if (div_zero) begin
            state_d  = DONE;
            valid_d  = 1'b1;
            result_d = bus.i_op[1] ? bus.i_dividend : '1;
          end else if (sgn_ovf) begin
            state_d  = DONE;
            valid_d  = 1'b1;
            result_d = bus.i_op[1] ? '0 : bus.i_dividend;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (abs_dvd < abs_dvs) begin
            state_d = FIX;
            quo_d   = '0;
            rem_d   = abs_dvd;
          end
`endif
          else begin
            state_d = CALC;
            cnt_d   = CNT_W'(XLEN);
            rem_d   = '0;
            quo_d   = abs_dvd;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[XLEN-2:0], step_bit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = op_rem_q ? fix_rem : fix_quo;
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        // Hand-off edge returns to IDLE; acceptance reopens one cycle later.
        if (bus.i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      op_rem_q <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      op_rem_q <= op_rem_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// =============================================================================
// tb_seq_divider : directed vectors with a queue scoreboard for seq_divider
// Rev 1.0
// =============================================================================
`timescale 1ns/1ps
module tb_seq_divider;
  import div_pkg::*;

  localparam int XLEN        = 32;
  localparam int LAT_CALC    = XLEN + 2;
  localparam int LAT_SPECIAL = 1;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SMALL   = 2;
`else
  localparam int LAT_SMALL   = XLEN + 2;
`endif

  typedef struct {
    logic [XLEN-1:0] result;
    int              lat;
    int              acc_cyc;
    string           name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic have_cur = 1'b0;
  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  int   cyc      = 0;
  int   n_vec    = 0;
  int   n_err    = 0;

  seq_divider_if #(.XLEN(XLEN)) bus ();

  seq_divider #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, required %b", name, got, exp);
    end
  endtask

  // Monitor: first o_valid cycle pops an expectation and checks latency;
  // every o_valid cycle checks the held result until it is handed off.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid) begin
      if (!have_cur) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: got result 0x%08h, required no response", bus.o_result);
        end else begin
          cur      = sb.pop_front();
          have_cur = 1'b1;
          check({cur.name, "_latency"}, XLEN'(cyc - cur.acc_cyc + 1), XLEN'(cur.lat));
        end
      end
      if (have_cur) begin
        check(cur.name, bus.o_result, cur.result);
        if (bus.i_ready) have_cur = 1'b0;
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 just after acceptance.
  task automatic issue(input string name, input div_op_e op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
    int   guard;
    exp_t e;
    guard = 0;
    while (bus.o_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_accept: o_ready low for %0d cycles, required high", name, guard);
      return;
    end
    bus.i_valid    = 1'b1;
    bus.i_op       = op;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    @(posedge clk); #1;
    e.result  = exp;
    e.lat     = lat;
    e.acc_cyc = cyc;
    e.name    = name;
    sb.push_back(e);
    bus.i_valid    = 1'b0;
    bus.i_op       = DIVU;
    bus.i_dividend = 32'hDEAD_BEEF;
    bus.i_divisor  = 32'h0000_0001;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((sb.size() != 0 || have_cur) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check_bit({name, "_drained"}, (sb.size() == 0 && !have_cur), 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    bus.i_valid    = 1'b0;
    bus.i_op       = DIV;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    bus.i_ready    = 1'b1;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("reset_ready", bus.o_ready, 1'b1);
    check_bit("reset_valid", bus.o_valid, 1'b0);
    check_bit("reset_busy", bus.o_busy, 1'b0);
    check("reset_result", bus.o_result, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue("divu_100_7",   DIVU, 32'd100,       32'd7,         32'd14,        LAT_CALC);
    issue("remu_100_7",   REMU, 32'd100,       32'd7,         32'd2,         LAT_CALC);
    issue("div_m7_2",     DIV,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  LAT_CALC);
    issue("rem_m7_2",     REM,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  LAT_CALC);
    issue("rem_7_m2",     REM,  32'd7,         32'hFFFFFFFE,  32'd1,         LAT_CALC);
    issue("divu_5_0",     DIVU, 32'd5,         32'd0,         32'hFFFFFFFF,  LAT_SPECIAL);
    issue("rem_m5_0",     REM,  32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  LAT_SPECIAL);
    issue("div_m5_0",     DIV,  32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  LAT_SPECIAL);
    issue("remu_7_0",     REMU, 32'd7,         32'd0,         32'd7,         LAT_SPECIAL);
    issue("div_ovf",      DIV,  32'h80000000,  32'hFFFFFFFF,  32'h80000000,  LAT_SPECIAL);
    issue("rem_ovf",      REM,  32'h80000000,  32'hFFFFFFFF,  32'd0,         LAT_SPECIAL);
    issue("divu_min_max", DIVU, 32'h80000000,  32'hFFFFFFFF,  32'd0,         LAT_SMALL);
    issue("div_min_2",    DIV,  32'h80000000,  32'd2,         32'hC0000000,  LAT_CALC);
    issue("rem_min_3",    REM,  32'h80000000,  32'd3,         32'hFFFFFFFE,  LAT_CALC);
    issue("remu_max_10",  REMU, 32'hFFFFFFFF,  32'd10,        32'd5,         LAT_CALC);
    issue("divu_3_10",    DIVU, 32'd3,         32'd10,        32'd0,         LAT_SMALL);
    issue("rem_0_5",      REM,  32'd0,         32'd5,         32'd0,         LAT_SMALL);
    issue("div_m3_10",    DIV,  32'hFFFFFFFD,  32'd10,        32'd0,         LAT_SMALL);
    issue("rem_m3_10",    REM,  32'hFFFFFFFD,  32'd10,        32'hFFFFFFFD,  LAT_SMALL);
    wait_drain("directed");

    // Backpressure: result must hold and new requests must be ignored.
    bus.i_ready = 1'b0;
    issue("bp_divu", DIVU, 32'd1000, 32'd9, 32'd111, LAT_CALC);
    guard = 0;
    while (bus.o_valid !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check_bit("bp_valid_seen", bus.o_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      bus.i_valid    = 1'b1;
      bus.i_op       = DIVU;
      bus.i_dividend = 32'd50;
      bus.i_divisor  = 32'd5;
      @(negedge clk);
      check_bit("bp_ready_low", bus.o_ready, 1'b0);
      check_bit("bp_valid_held", bus.o_valid, 1'b1);
      check_bit("bp_busy", bus.o_busy, 1'b1);
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_bit("bp_valid_drop", bus.o_valid, 1'b0);
    check_bit("bp_ready_back", bus.o_ready, 1'b1);
    check_bit("bp_busy_drop", bus.o_busy, 1'b0);
    @(posedge clk); #1;
    wait_drain("backpressure");

    // Reset mid-iteration: the in-flight result must never appear.
    issue("rst_abort", DIVU, 32'hFFFFFFFF, 32'd3, 32'h55555555, LAT_CALC);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check_bit("rst_busy", bus.o_busy, 1'b0);
    check_bit("rst_valid", bus.o_valid, 1'b0);
    check_bit("rst_ready", bus.o_ready, 1'b1);
    repeat (50) @(posedge clk);
    #1;
    issue("post_rst", DIVU, 32'd100, 32'd7, 32'd14, LAT_CALC);
    wait_drain("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Complements the Booth multiplier datapath.
- Sits in the execute stage beside the multiplier and uses a valid/ready handshake on both sides.
- Holds one operation in flight and produces exactly one result per accepted request.

Parameters:
XLEN, 32, operand and result width in bits (>= 8, power of 2)
CNT_W, $clog2(XLEN)+1, width of the iteration counter (derived, not overridden)

Ports:
i_clk  input  1  clock; every flop updates on the rising edge
i_rst_n  input  1  reset; synchronous, active-low
i_valid  input  1  request valid
o_ready  output  1  divider can accept a request (high only in IDLE)
i_op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
i_dividend  input  XLEN  rs1 value
i_divisor  input  XLEN  rs2 value
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result
o_result  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)
o_busy  output  1  high in any state except IDLE

Behaviour:
- Reset (i_rst_n low at a clock edge):
  - State goes to IDLE; the counter clears.
  - Registered outputs: o_ready=1, o_valid=0, o_busy=0, o_result=0.
  - Reset overrides everything, including a mid-iteration or DONE state. The pending result is discarded and never presented.
- States: IDLE, CALC, FIX, DONE.
- Accept: in IDLE, i_valid=1 latches i_op and the operands.
  - Signed ops (op[0]=0) store the absolute values and record the quotient sign (dividend_msb ^ divisor_msb) and the remainder sign (dividend_msb).
  - Accept transitions:
    - divisor==0 -> DONE. Quotient = all ones; remainder = dividend unmodified.
    - Signed overflow (dividend=1<<(XLEN-1), divisor all ones) -> DONE. Quotient = dividend; remainder = 0.
    - Otherwise -> CALC, with counter=XLEN, partial remainder=0, quotient register=|dividend|.
- CALC, one bit per cycle:
  - {rem,quo} shift left by 1.
  - trial = rem_shifted - |divisor|, computed at XLEN+1 bits.
  - If trial is non-negative, rem = trial and quo[0] = 1; else quo[0] = 0.
  - Counter decrements. When the counter reaches 1, the next state is FIX.
- FIX (1 cycle):
  - Apply the recorded signs: two's-complement negate the quotient and/or remainder where required.
  - Select by op[1] and register into o_result. Next state is DONE.
- DONE: o_valid=1 and o_result is held stable until i_ready=1; then -> IDLE.
  - If i_ready is already high on the first DONE cycle, the handshake completes that cycle.
  - No new request is accepted in the same cycle as result hand-off. o_ready rises the following cycle.
- Latency, acceptance edge to first o_valid cycle:
  - Normal operation: XLEN+2 cycles (34 for XLEN=32).
  - Special cases: 1 cycle.
- i_valid while busy is ignored; the requester must hold its request until o_ready.
- Operand inputs are sampled only at acceptance. Later changes have no effect.
- Arithmetic:
  - |x| of 1<<(XLEN-1) stays 1<<(XLEN-1), interpreted unsigned.
  - All subtraction is unsigned at XLEN+1 bits; no overflow is possible within CALC.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: at acceptance, if |dividend| < |divisor| (unsigned, divisor nonzero, not the overflow case), go directly to FIX with quotient 0 and remainder |dividend|. FIX reapplies the signs, giving latency 2.
  - A zero dividend is covered by this rule.
- Undefined: no early exit; every non-special operation takes XLEN+2 cycles.

Decomposition:
- Package div_pkg holds:
  - the div_op_e enum (DIV, DIVU, REM, REMU) with funct3[1:0] encodings;
  - the div_state_e enum (IDLE, CALC, FIX, DONE);
  - a localparam for the overflow dividend pattern function;
  - the helper function abs_xlen.
- One sub-module is natural: div_step. It is purely combinational and takes the shifted remainder plus divisor, returning the next remainder and the quotient bit. This keeps the (XLEN+1)-bit subtract isolated so it can later be mapped onto carry_4 chains.

Test Plan:
- DIVU 100/7, i_ready tied high -> o_result=14, o_valid exactly 34 cycles after acceptance; REMU same operands -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); REM 7 / 0xFFFFFFFE (-2) -> 1.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REM 0xFFFFFFFB/0 -> 0xFFFFFFFB; each o_valid 1 cycle after acceptance.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; latency 1.
- Backpressure:
  - Hold i_ready low 5 cycles in DONE -> o_result stable, o_ready=0, new i_valid ignored.
  - Raise i_ready -> o_valid drops next cycle and o_ready=1.
- Reset mid-CALC: drive i_rst_n low at iteration 10 for one edge -> o_busy=0, o_valid=0, o_ready=1 next cycle, no stale result later.
  - With DIV_EARLY_OUT_EN defined, additionally: DIVU 3/10 -> 0 at latency 2.
